// File: rtl/vec_add_seq.sv
// Vector-add sequencer: streams len A+B elements into C and arbitrates host B-memory ops.
// Optional VEC_CARRY_CNT_EN adds a carry_cnt output counting C writes with the carry bit set.
module vec_add_seq #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              btnc,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              host_req,
    input  logic              host_inc,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [DATA_W-1:0] a_rdata,
    input  logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              b_we,
    output logic [ADDR_W-1:0] b_waddr,
    output logic [DATA_W-1:0] b_wdata,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_waddr,
    output logic [DATA_W:0]   c_wdata,
    output logic              busy,
    output logic              done,
    output logic              host_ack
`ifdef VEC_CARRY_CNT_EN
    ,
    output logic [ADDR_W:0]   carry_cnt
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StFlush,
        StDone,
        StHrd,
        StHwr
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   rem_q;
    logic              c_we_q;
    logic [ADDR_W-1:0] c_waddr_q;
    logic [ADDR_W-1:0] b_waddr_q;
    logic [DATA_W-1:0] hwdata_q;
    logic              hinc_q;
    logic              last_issue;
    logic              vec_accept;

    assign last_issue = (rem_q == (ADDR_W+1)'(1));
    // Host requests win over start in IDLE.
    assign vec_accept = (state_q == StIdle) && !host_req && start;

    always_ff @(posedge clk) begin
        if (btnc) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (host_req) begin
                    state_d = host_inc ? StHrd : StHwr;
                end else if (start) begin
                    state_d = (len == '0) ? StDone : StRun;
                end
            end
            StRun:   state_d = last_issue ? StFlush : StRun;
            StFlush: state_d = StDone;
            StDone:  state_d = StIdle;
            StHrd:   state_d = StHwr;
            StHwr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (btnc) begin
            addr_q    <= '0;
            rem_q     <= '0;
            c_we_q    <= 1'b0;
            c_waddr_q <= '0;
            b_waddr_q <= '0;
            hwdata_q  <= '0;
            hinc_q    <= 1'b0;
        end else begin
            // Each issued address gets its C write one cycle later, when read data arrives.
            c_we_q <= (state_q == StRun);
            if (state_q == StRun) begin
                c_waddr_q <= addr_q;
            end
            if (state_q == StIdle && host_req) begin
                b_waddr_q <= host_addr;
                hwdata_q  <= host_wdata;
                hinc_q    <= host_inc;
                if (host_inc) begin
                    addr_q <= host_addr;
                end
            end else if (vec_accept) begin
                addr_q <= base_addr;
                rem_q  <= len;
            end else if (state_q == StRun) begin
                rem_q <= rem_q - (ADDR_W+1)'(1);
                if (!last_issue) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        b_we     = 1'b0;
        host_ack = 1'b0;
        b_wdata  = '0;
        unique case (state_q)
            StRun, StFlush: busy = 1'b1;
            StDone:         done = 1'b1;
            StHwr: begin
                b_we     = 1'b1;
                host_ack = 1'b1;
                b_wdata  = hinc_q ? (b_rdata + DATA_W'(1)) : hwdata_q;
            end
            default: ;
        endcase
    end

    assign mem_addr = addr_q;
    assign b_waddr  = b_waddr_q;
    assign c_we     = c_we_q;
    assign c_waddr  = c_waddr_q;
    assign c_wdata  = c_we_q ? ({1'b0, a_rdata} + {1'b0, b_rdata}) : '0;

`ifdef VEC_CARRY_CNT_EN
    logic [ADDR_W:0] carry_q;

    always_ff @(posedge clk) begin
        if (btnc || vec_accept) begin
            carry_q <= '0;
        end else if (c_we_q && c_wdata[DATA_W]) begin
            carry_q <= carry_q + (ADDR_W+1)'(1);
        end
    end

    assign carry_cnt = carry_q;
`endif

endmodule

// File: doc/vec_add_seq.md
# vec_add_seq

Sequencer and arbiter for the vector-add memory datapath: owns the shared A/B read address, streams `len` elements from `base_addr` through the adder into C memory at one element per cycle, and arbitrates the switch-driven B-memory write/increment requests against running vector operations. Sits between the board-level control decode (`sw`/`btnc`) and the A, B, C block memories, replacing direct switch control of the memory address.

## Interface
- `ADDR_W`, 10, memory address width (1024 entries)
- `DATA_W`, 4, A/B element width; C is `DATA_W+1`

- `clk`  in  1  system clock, all logic on rising edge
- `btnc`  in  1  reset, synchronous, active-high
- `start`  in  1  level request to run a vector add; held until `busy` rises
- `base_addr`  in  ADDR_W  first element address, sampled with `start`
- `len`  in  ADDR_W+1  element count 0..2^ADDR_W, sampled with `start`
- `host_req`  in  1  level request for a B-memory op; held until `host_ack`
- `host_inc`  in  1  0 = write `host_wdata`, 1 = increment B[`host_addr`]; sampled with `host_req`
- `host_addr`  in  ADDR_W  B address for host op
- `host_wdata`  in  DATA_W  host write data
- `a_rdata`, `b_rdata`  in  DATA_W  A/B read data, valid one cycle after `mem_addr`
- `mem_addr`  out  ADDR_W  shared A/B read address
- `b_we`  out  1  B write strobe; `b_waddr` out ADDR_W; `b_wdata` out DATA_W
- `c_we`  out  1  C write strobe; `c_waddr` out ADDR_W; `c_wdata` out DATA_W+1
- `busy`  out  1  vector op in progress
- `done`  out  1  one-cycle pulse at vector op completion
- `host_ack`  out  1  one-cycle pulse when host op's B write occurs

## Operation
- States: IDLE, RUN, FLUSH, DONE, HRD, HWR.
- IDLE: `host_req` beats `start` if both high. `host_req` & !`host_inc` → HWR; `host_req` & `host_inc` → HRD; else `start` → RUN (`len`≠0) or DONE (`len`=0).
- RUN: issue `mem_addr` = base+i, i=0..len-1, one per cycle; after the last issue → FLUSH.
- Write pipeline: cycle after each issue, `c_we`=1, `c_waddr` = issued address, `c_wdata` = `a_rdata`+`b_rdata` zero-extended to DATA_W+1 (no loss).
- FLUSH: final C write; → DONE. DONE: `done`=1 for one cycle; → IDLE.
- HRD: `mem_addr`=`host_addr`; → HWR. HWR: `b_we`=1, `b_waddr`=`host_addr`, `b_wdata` = `host_wdata` (write) or `b_rdata`+1 mod 2^DATA_W (inc, 4'hF wraps to 0); `host_ack`=1; → IDLE.
- Host requests wait (no ack) throughout RUN/FLUSH/DONE; `start` is ignored outside IDLE.
- Address wrap: base+i computed mod 2^ADDR_W; `len`=1024 with any base covers every address exactly once.
- `len` > 2^ADDR_W impossible by width; `len`=0 writes nothing and still pulses `done`.

## Timing
- Reset: state IDLE; `mem_addr`, `b_waddr`, `b_wdata`, `c_waddr`, `c_wdata` = 0; `b_we`, `c_we`, `busy`, `done`, `host_ack` = 0; element counter 0.
- `start` sampled at edge T in IDLE: `busy`=1 from T+1 through T+len+1; `mem_addr`=base+i at T+1+i; `c_we` for element i at T+2+i; `done` at T+len+2 with `busy`=0. `len`=0: `done` at T+1, `busy` never asserts.
- Host write: `host_req` sampled at H → `b_we`,`host_ack` at H+1. Increment: read at H+1, `b_we`,`host_ack` at H+2.
- Earliest next request accepted the cycle after `done`/`host_ack`.
- `btnc` mid-operation: next cycle all strobes low, IDLE; partial C writes stay, no further writes, no `done`/`host_ack`.

## Configuration
- `VEC_CARRY_CNT_EN` defined: adds output `carry_cnt` (ADDR_W+1 bits), cleared on reset and when a vector op starts, incremented on each C write whose `c_wdata[DATA_W]`=1; holds value after `done`.
- Undefined: no `carry_cnt` port, no counter logic; all other behaviour identical.

## Test plan
- Reset then `start`, base=0, len=4, A={1,2,3,4}, B={F,1,8,0} → C[0..3]={10,03,0B,04}, `done` exactly 6 cycles after start sample, `carry_cnt`=1 if enabled.
- Host write B[0]=5 then inc B[0] → B[0]=5 after ack 1 cycle after req, then 6 after ack 2 cycles after req; B[0]=F inc → 0.
- `start` and `host_req` high same IDLE cycle → host op completes first, vector op starts the cycle after `host_ack`; host_req raised during RUN → no ack until after `done`.
- base=0x3FE, len=4 → C writes at 0x3FE, 0x3FF, 0x000, 0x001 in order; len=0 → `done` next cycle, no `c_we`.
- `btnc` pulsed at element 2 of len=8 → only C[base..base+1] (and at most base+2) written, all outputs return to reset values, no `done`.
